// File: rtl/icache_refill.sv
// Instruction-cache miss handler: issues one block read per miss, gathers the
// response beats into a full block and writes it to the array for one cycle.
module icache_refill #(
    parameter int XLEN         = 32,
    parameter int BLOCK_WIDTH  = 256,
    parameter int BUS_WIDTH    = 64,
    parameter int OFFSET_WIDTH = 5,
    parameter int BEATS        = BLOCK_WIDTH / BUS_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   miss_valid,
    input  logic [XLEN-1:0]        miss_addr,
    output logic                   miss_ready,
    input  logic                   flush,
    output logic                   mem_req_valid,
    output logic [XLEN-1:0]        mem_req_addr,
    input  logic                   mem_req_ready,
    input  logic                   mem_resp_valid,
    input  logic [BUS_WIDTH-1:0]   mem_resp_data,
    output logic                   fill_wen,
    output logic [XLEN-1:0]        fill_addr,
    output logic [BLOCK_WIDTH-1:0] fill_block,
    output logic                   busy
);

    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RECV,
        S_FILL,
        S_DRAIN
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BLOCK_WIDTH-1:0] buf_q, buf_d;
    logic [XLEN-1:0]        addr_q, addr_d;
    logic [XLEN-1:0]        fill_addr_q, fill_addr_d;
    logic [BLOCK_WIDTH-1:0] fill_block_q, fill_block_d;
    logic                   beat_last;

    // Offset bits are dropped on purpose: requests are always block aligned.
    logic unused_offset;
    assign unused_offset = ^miss_addr[OFFSET_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            buf_q        <= '0;
            addr_q       <= '0;
            fill_addr_q  <= '0;
            fill_block_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            buf_q        <= buf_d;
            addr_q       <= addr_d;
            fill_addr_q  <= fill_addr_d;
            fill_block_q <= fill_block_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        buf_d        = buf_q;
        addr_d       = addr_q;
        fill_addr_d  = fill_addr_q;
        fill_block_d = fill_block_q;
        beat_last    = (cnt_q == CNT_LAST);

        case (state_q)
            S_IDLE: begin
                if (miss_valid && !flush) begin
                    addr_d  = {miss_addr[XLEN-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // A request accepted alongside a flush still returns beats, so drain them.
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = flush ? S_DRAIN : S_RECV;
                end else if (flush) begin
                    state_d = S_IDLE;
                end
            end
            S_RECV: begin
                if (mem_resp_valid) begin
                    for (int i = 0; i < BEATS; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            buf_d[i*BUS_WIDTH +: BUS_WIDTH] = mem_resp_data;
                        end
                    end
                    cnt_d = beat_last ? '0 : cnt_q + CNT_ONE;
                end
                // If the final beat lands with the flush, nothing is left to drain.
                if (flush) begin
                    state_d = (mem_resp_valid && beat_last) ? S_IDLE : S_DRAIN;
                end else if (mem_resp_valid && beat_last) begin
                    state_d      = S_FILL;
                    fill_addr_d  = addr_q;
                    fill_block_d = buf_d;
                end
            end
            S_DRAIN: begin
                if (mem_resp_valid) begin
                    cnt_d = beat_last ? '0 : cnt_q + CNT_ONE;
                    if (beat_last) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_FILL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign miss_ready    = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign mem_req_valid = (state_q == S_REQ);
    assign mem_req_addr  = addr_q;
    assign fill_wen      = (state_q == S_FILL);
    assign fill_addr     = fill_addr_q;
    assign fill_block    = fill_block_q;

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: drivers push expected requests and fills
// into queues; a negedge monitor pops and compares when the DUT presents them.
module tb_icache_refill;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         miss_valid = 1'b0;
    logic [31:0]  miss_addr = '0;
    logic         miss_ready;
    logic         flush = 1'b0;
    logic         mem_req_valid;
    logic [31:0]  mem_req_addr;
    logic         mem_req_ready = 1'b0;
    logic         mem_resp_valid = 1'b0;
    logic [63:0]  mem_resp_data = '0;
    logic         fill_wen;
    logic [31:0]  fill_addr;
    logic [255:0] fill_block;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int fills_seen = 0;
    int fills_exp = 0;

    logic [31:0]  exp_req_q[$];
    logic [31:0]  exp_addr_q[$];
    logic [255:0] exp_blk_q[$];

    icache_refill #(
        .XLEN(32), .BLOCK_WIDTH(256), .BUS_WIDTH(64), .OFFSET_WIDTH(5)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
        .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .fill_wen(fill_wen), .fill_addr(fill_addr), .fill_block(fill_block),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every request handshake and every fill cycle must match a queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req_valid && mem_req_ready) begin
                if (exp_req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_unexpected: got request %0h expected none", mem_req_addr);
                end else begin
                    chk("req_addr", mem_req_addr, exp_req_q.pop_front());
                end
            end
            if (fill_wen) begin
                fills_seen++;
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fill_unexpected: got fill at %0h expected none", fill_addr);
                end else begin
                    chk("fill_addr", fill_addr, exp_addr_q.pop_front());
                    chk("fill_block", fill_block, exp_blk_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_miss(input logic [31:0] a);
        miss_valid = 1'b1;
        miss_addr  = a;
        tick();
        miss_valid = 1'b0;
    endtask

    task automatic req_handshake(input logic [31:0] a, input int stall);
        mem_req_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("req_hold_valid", mem_req_valid, 1);
            chk("req_hold_addr", mem_req_addr, a);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
    endtask

    task automatic beat(input logic [63:0] d);
        mem_resp_valid = 1'b1;
        mem_resp_data  = d;
        tick();
        mem_resp_valid = 1'b0;
    endtask

    task automatic refill(input logic [31:0] a, input logic [31:0] blk_a,
                          input logic [63:0] b0, input logic [63:0] b1,
                          input logic [63:0] b2, input logic [63:0] b3,
                          input int stall, input int gap, input bit flush_in_fill);
        exp_req_q.push_back(blk_a);
        exp_addr_q.push_back(blk_a);
        exp_blk_q.push_back({b3, b2, b1, b0});
        fills_exp++;
        send_miss(a);
        req_handshake(blk_a, stall);
        beat(b0);
        beat(b1);
        repeat (gap) tick();
        beat(b2);
        chk("no_early_fill", fill_wen, 0);
        beat(b3);
        @(negedge clk);
        chk("fill_latency", fill_wen, 1);
        if (flush_in_fill) flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("miss_ready_return", miss_ready, 1);
        chk("fill_wen_one_cycle", fill_wen, 0);
    endtask

    initial begin
        // Reset values
        repeat (2) tick();
        chk("rst_miss_ready", miss_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_fill_wen", fill_wen, 0);
        chk("rst_fill_addr", fill_addr, 0);
        chk("rst_fill_block", fill_block, 0);
        rst_n = 1'b1;
        tick();

        // Basic refill
        refill(32'h0000_1234, 32'h0000_1220,
               64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 0, 0, 1'b0);
        chk("fill_addr_hold", fill_addr, 32'h0000_1220);
        chk("fill_block_hold", fill_block,
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        // Request backpressure for 5 cycles
        refill(32'h0000_8F3C, 32'h0000_8F20,
               64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
               64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_8000_0000, 5, 0, 1'b0);

        // Gapped beats, with a flush landing during the fill cycle
        refill(32'h0001_005C, 32'h0001_0040,
               64'hA5A5_A5A5_5A5A_5A5A, 64'h0000_0000_FFFF_FFFF,
               64'hFFFF_FFFF_0000_0000, 64'h8000_0000_0000_0001, 0, 3, 1'b1);

        // Miss coincident with flush in IDLE is ignored
        miss_valid = 1'b1;
        miss_addr  = 32'h0BAD_0000;
        flush      = 1'b1;
        tick();
        miss_valid = 1'b0;
        flush      = 1'b0;
        chk("miss_flush_ignored", busy, 0);
        chk("miss_flush_no_req", mem_req_valid, 0);

        // Flush in RECV after 2 beats: remaining beats drained, no fill
        exp_req_q.push_back(32'h2000_0000);
        send_miss(32'h2000_0010);
        req_handshake(32'h2000_0000, 0);
        beat(64'hAAAA_AAAA_AAAA_AAAA);
        beat(64'hBBBB_BBBB_BBBB_BBBB);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("recv_flush_busy", busy, 1);
        beat(64'hCCCC_CCCC_CCCC_CCCC);
        chk("recv_flush_not_ready", miss_ready, 0);
        beat(64'hDDDD_DDDD_DDDD_DDDD);
        chk("recv_flush_drained", miss_ready, 1);
        chk("recv_flush_fill_kept", fill_addr, 32'h0001_0040);

        // New miss after the flush refills correctly
        refill(32'h3000_00E4, 32'h3000_00E0,
               64'h1000_0000_0000_0001, 64'h2000_0000_0000_0002,
               64'h3000_0000_0000_0003, 64'h4000_0000_0000_0004, 1, 0, 1'b0);

        // Flush in REQ before ready: no handshake, back to IDLE
        send_miss(32'h4000_0000);
        @(negedge clk);
        chk("req_flush_pending", mem_req_valid, 1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("req_flush_idle", miss_ready, 1);
        chk("req_flush_no_req", mem_req_valid, 0);

        // Flush coincident with handshake: 4 beats drained, no fill
        exp_req_q.push_back(32'h5000_0020);
        send_miss(32'h5000_0024);
        mem_req_ready = 1'b1;
        flush = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        flush = 1'b0;
        chk("hs_flush_drain", busy, 1);
        beat(64'h5555_0000_0000_0000);
        beat(64'h5555_1111_0000_0000);
        beat(64'h5555_2222_0000_0000);
        chk("hs_flush_not_ready", miss_ready, 0);
        beat(64'h5555_3333_0000_0000);
        chk("hs_flush_drained", miss_ready, 1);
        chk("hs_flush_fill_kept", fill_addr, 32'h3000_00E0);

        // Async reset during beat 1 of RECV
        exp_req_q.push_back(32'h6000_0040);
        send_miss(32'h6000_0048);
        req_handshake(32'h6000_0040, 0);
        beat(64'h6666_6666_6666_6666);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'h7777_7777_7777_7777;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_miss_ready", miss_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_req_valid", mem_req_valid, 0);
        chk("arst_fill_wen", fill_wen, 0);
        chk("arst_fill_addr", fill_addr, 0);
        chk("arst_fill_block", fill_block, 0);
        mem_resp_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Fresh miss after reset
        refill(32'h7000_0000, 32'h7000_0000,
               64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0,
               64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 2, 1, 1'b0);

        repeat (3) tick();
        chk("req_queue_empty", exp_req_q.size(), 0);
        chk("fill_queue_empty", exp_addr_q.size(), 0);
        chk("fill_count", fills_seen, fills_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Miss handler directly downstream of the icache tag/data array.
- Accepts a miss address from fetch and issues one block read to the memory side.
- Assembles the returned beats into a full cache block, then drives the array's write port (addr/wen/wr_block) for exactly one cycle.
- Supports a fetch flush (redirect) that cancels the refill without corrupting the array.

Parameters:
- XLEN, 32, address width.
- BLOCK_WIDTH, 256, cache block width in bits.
- BUS_WIDTH, 64, memory response data width; BLOCK_WIDTH/BUS_WIDTH is an integer >= 2.
- OFFSET_WIDTH, 5, log2(BLOCK_WIDTH/8).
- BEATS, BLOCK_WIDTH/BUS_WIDTH, derived; beats per block.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- miss_valid  in  1  fetch reports a miss.
- miss_addr  in  XLEN  missing fetch address; 32-bit aligned.
- miss_ready  out  1  refill can accept a miss; high only in IDLE.
- flush  in  1  fetch redirect; cancel the outstanding refill.
- mem_req_valid  out  1  block read request.
- mem_req_addr  out  XLEN  block-aligned request address.
- mem_req_ready  in  1  memory accepts the request.
- mem_resp_valid  in  1  response beat valid; beats arrive in order, no backpressure.
- mem_resp_data  in  BUS_WIDTH  response beat.
- fill_wen  out  1  to array wen.
- fill_addr  out  XLEN  to array addr; block-aligned.
- fill_block  out  BLOCK_WIDTH  to array wr_block.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE, beat counter=0, block buffer=0, latched address=0.
  - miss_ready=1, busy=0.
  - mem_req_valid=0, fill_wen=0, fill_addr=0, fill_block=0.
- States: IDLE, REQ, RECV, FILL, DRAIN.
- IDLE:
  - miss_ready=1.
  - If miss_valid & !flush: latch {miss_addr[XLEN-1:OFFSET_WIDTH], OFFSET_WIDTH'b0} and go to REQ.
  - If miss_valid & flush in the same cycle: ignore the miss.
- REQ:
  - mem_req_valid=1 and mem_req_addr=latched address, both held stable until the handshake.
  - On mem_req_valid & mem_req_ready: go to RECV, counter=0.
  - If flush arrives before the handshake: go to IDLE, no request issued.
  - Handshake and flush in the same cycle: the request is consumed; go to DRAIN.
- RECV:
  - Each mem_resp_valid writes mem_resp_data to buffer bits [cnt*BUS_WIDTH +: BUS_WIDTH] (beat 0 = LSBs), then cnt++.
  - On the beat with cnt==BEATS-1: go to FILL.
  - flush: go to DRAIN, keeping the current cnt. A beat arriving in the flush cycle is counted.
- DRAIN:
  - Count and discard remaining beats. On the last beat go to IDLE. fill_wen stays 0.
- FILL (exactly 1 cycle):
  - fill_wen=1, fill_addr=latched address, fill_block=buffer; then go to IDLE.
  - flush during FILL does not suppress the write: the block is valid memory data.
- fill_addr/fill_block are registered and hold their last values outside FILL. fill_wen is 0 outside FILL.
- Latency: last response beat at cycle T produces fill_wen=1 at T+1. miss_ready returns at T+2.
- mem_resp_valid in IDLE/REQ/FILL is a protocol error: ignored, no state change.
- Counter width is clog2(BEATS); it wraps to 0 on the last beat.
- Single outstanding refill only: miss_valid while busy is not accepted (miss_ready=0). Fetch holds it.
- Reset mid-operation: immediate return to reset values. The memory side is reset by the same rst_n.

Test Plan:
- Basic refill: miss_addr=0x0000_1234, mem_req_ready=1 → mem_req_addr=0x0000_1220. Beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 one per cycle → one-cycle fill_wen with fill_addr=0x1220, fill_block={0x44..,0x33..,0x22..,0x11..}, then miss_ready=1.
- Backpressure: hold mem_req_ready=0 for 5 cycles → mem_req_valid and mem_req_addr stable all 5 cycles; exactly one request handshake.
- Gapped beats: insert 3 idle cycles between beats 1 and 2 → same fill_block; fill_wen exactly 1 cycle after beat 3.
- Flush in RECV after 2 beats → remaining 2 beats absorbed, fill_wen never asserts, miss_ready=1 after the 4th beat. A new miss then refills correctly.
- Flush in REQ before ready → no handshake, immediate IDLE. Flush coincident with the handshake → DRAIN consumes 4 beats, no fill.
- Async reset asserted during RECV (beat 1) → all outputs at reset values without a clock edge. After release, a fresh miss completes normally.
